sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Parametrised synchronous FIFO, next generation of the UART buffer FIFO. Generalises width, depth and read mode (registered read or first-word-fall-through). Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, full-with-read write pass, and sticky overflow/underflow error flags. Used for the UART TX/RX buffers and any other single-clock buffering in the SoC.

Parameters:
DataWidth, 32, data word width in bits (>=1)
Depth, 16, number of entries; power of two, >=2; elaboration $error otherwise
Fwft, 0, read mode: 0 = registered read (data one cycle after accepted read), 1 = first-word-fall-through
AlmostFullThresh, Depth-2, almost_full_o asserted when count >= this value (1..Depth)
AlmostEmptyThresh, 1, almost_empty_o asserted when count <= this value (0..Depth-1)
PointerWidth (localparam), $clog2(Depth), address width; pointers carry one extra wrap bit

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
wr_en_i  in  1  write request
wr_data_i  in  DataWidth  write data
rd_en_i  in  1  read request (in Fwft=1: acknowledge/pop of rd_data_o)
flush_i  in  1  synchronous empty of FIFO contents
clr_err_i  in  1  clears sticky error flags
rd_data_o  out  DataWidth  read data
full_o  out  1  Depth entries stored
empty_o  out  1  zero entries stored
almost_full_o  out  1  count >= AlmostFullThresh
almost_empty_o  out  1  count <= AlmostEmptyThresh
count_o  out  PointerWidth+1  current occupancy, 0..Depth
overflow_o  out  1  sticky: write request rejected
underflow_o  out  1  sticky: read request rejected

Behaviour:
- One clock clk_i; reset rst_i is synchronous and active-high.
- Reset: pointers 0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AlmostFullThresh==0 ? 1 : 0, i.e. 0 for legal values), overflow_o=0, underflow_o=0, rd_data_o=0 in Fwft=0. Memory contents are not reset.
- Pointers rd_ptr/wr_ptr are PointerWidth+1 bits; MSB is the wrap bit. empty = (rd_ptr==wr_ptr). full = same index, wrap bits differ. count_o = wr_ptr - rd_ptr, modulo 2^(PointerWidth+1).
- Status outputs are combinational from registered pointers only, never from this cycle's requests.
- rd_acc = rd_en_i & ~empty_o & ~flush_i.
- wr_acc = wr_en_i & ~flush_i & (~full_o | rd_acc). A write while full is accepted when a read is accepted in the same cycle.
- Empty with rd_en_i and wr_en_i both high: write accepted, read rejected. No bypass.
- Accepted write: mem[wr_ptr index] <= wr_data_i; wr_ptr+1.
- Accepted read: rd_ptr+1.
  - Fwft=0: rd_data_o <= mem[rd_ptr index] on the same edge, so data is valid the cycle after the accepted read. rd_data_o holds its value otherwise.
  - Fwft=1: rd_data_o = mem[rd_ptr index] combinationally. It is valid whenever empty_o=0. A newly written word is visible the cycle after its write edge.
- Simultaneous accepted read and write: count unchanged.
- flush_i: both pointers <= 0 on the next edge. All requests that cycle are ignored and do not set error flags. rd_data_o (Fwft=0) and the error flags are unchanged. Reset has priority over flush.
- Error flags:
  - overflow_o set when wr_en_i & ~flush_i & ~wr_acc.
  - underflow_o set when rd_en_i & ~flush_i & empty_o.
  - clr_err_i clears both flags; a set condition in the same cycle wins over the clear.
- Pointer wrap-around is natural binary overflow; no special handling.

Test Plan:
- Depth=4, DataWidth=8, Fwft=0: reset, write 0x11,0x22,0x33,0x44 -> count_o 1,2,3,4; full_o=1 after the 4th edge; almost_full_o=1 at count 2; empty_o=0.
- Full FIFO (previous state), write 0x55 with no read -> rejected, overflow_o=1 and stays 1; count_o=4. Pulse clr_err_i -> overflow_o=0.
- Full FIFO, rd_en_i and wr_en_i with 0x66 together -> count_o stays 4, rd_data_o=0x11 next cycle; draining gives 0x22,0x33,0x44,0x66 in order.
- Empty FIFO, rd_en_i=1 -> underflow_o=1, rd_data_o unchanged, count_o=0. Same cycle, wr_en_i with 0xA5 -> write accepted, count_o=1.
- Fwft=1: write 0x5A -> next cycle empty_o=0, rd_data_o=0x5A with no rd_en_i. Pop -> empty_o=1. Run 10 write/read cycles to cross the pointer wrap -> data order preserved.
- Partially filled (3 entries), assert flush_i together with wr_en_i and rd_en_i -> next cycle count_o=0, empty_o=1, no error flags set. Assert rst_i mid-burst -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// occupancy/threshold status, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned Depth             = 16,
    parameter int unsigned Fwft              = 0,
    parameter int unsigned AlmostFullThresh  = Depth - 2,
    parameter int unsigned AlmostEmptyThresh = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [DataWidth-1:0]         wr_data_i,
    input  logic                         rd_en_i,
    input  logic                         flush_i,
    input  logic                         clr_err_i,
    output logic [DataWidth-1:0]         rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(Depth):0]       count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int unsigned PointerWidth = $clog2(Depth);

    typedef logic [PointerWidth:0] ptr_t;

    localparam ptr_t PtrOne   = ptr_t'(1);
    localparam ptr_t WrapBit  = ptr_t'(Depth);
    localparam ptr_t AfThresh = ptr_t'(AlmostFullThresh);
    localparam ptr_t AeThresh = ptr_t'(AlmostEmptyThresh);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_flex: Depth must be a power of two >= 2");
    end

    logic [DataWidth-1:0] mem [Depth];
    ptr_t                 wr_ptr;
    ptr_t                 rd_ptr;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 ovf_set;
    logic                 udf_set;

    // Status derives only from registered pointers, never from this cycle's requests.
    assign count_o        = wr_ptr - rd_ptr;
    assign empty_o        = (rd_ptr == wr_ptr);
    assign full_o         = ((rd_ptr ^ wr_ptr) == WrapBit);
    assign almost_full_o  = (count_o >= AfThresh);
    assign almost_empty_o = (count_o <= AeThresh);

    assign rd_acc  = rd_en_i & ~empty_o & ~flush_i;
    assign wr_acc  = wr_en_i & ~flush_i & (~full_o | rd_acc);
    assign ovf_set = wr_en_i & ~flush_i & ~wr_acc;
    assign udf_set = rd_en_i & ~flush_i & empty_o;

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr[PointerWidth-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clr_err_i) begin
                overflow_o <= 1'b0;
            end
            if (udf_set) begin
                underflow_o <= 1'b1;
            end else if (clr_err_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    if (Fwft != 0) begin : g_fwft
        assign rd_data_o = mem[rd_ptr[PointerWidth-1:0]];
    end else begin : g_reg_read
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_data_o <= '0;
            end else if (rd_acc) begin
                rd_data_o <= mem[rd_ptr[PointerWidth-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: one registered-read and one FWFT instance,
// read data checked by per-instance monitors against queues of expected words.
module tb_sync_fifo_flex;
    logic clk;
    int   checks;
    int   errors;

    logic       rst0, wr0, rd0, fl0, ce0;
    logic [7:0] wd0, rdat0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic [2:0] cnt0;

    logic       rst1, wr1, rd1, fl1, ce1;
    logic [7:0] wd1, rdat1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    sync_fifo_flex #(.DataWidth(8), .Depth(4), .Fwft(0)) dut0 (
        .clk_i(clk), .rst_i(rst0), .wr_en_i(wr0), .wr_data_i(wd0), .rd_en_i(rd0),
        .flush_i(fl0), .clr_err_i(ce0), .rd_data_o(rdat0), .full_o(full0),
        .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
        .count_o(cnt0), .overflow_o(ovf0), .underflow_o(udf0)
    );

    sync_fifo_flex #(.DataWidth(8), .Depth(4), .Fwft(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .wr_en_i(wr1), .wr_data_i(wd1), .rd_en_i(rd1),
        .flush_i(fl1), .clr_err_i(ce1), .rd_data_o(rdat1), .full_o(full1),
        .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
        .count_o(cnt1), .overflow_o(ovf1), .underflow_o(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic op0(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c, input logic rs);
        wr0 = w; wd0 = d; rd0 = r; fl0 = f; ce0 = c; rst0 = rs;
        @(posedge clk); #1;
        wr0 = 0; rd0 = 0; fl0 = 0; ce0 = 0; rst0 = 0;
    endtask

    task automatic op1(input logic w, input logic [7:0] d, input logic r);
        wr1 = w; wd1 = d; rd1 = r;
        @(posedge clk); #1;
        wr1 = 0; rd1 = 0;
    endtask

    // Registered read: data of a read accepted at one edge is compared one cycle later.
    initial begin : mon0
        logic pend;
        logic [7:0] e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_data0_unexpected actual=%0h required=none", rdat0);
                end else begin
                    e = q0.pop_front();
                    chk("rd_data0", 32'(rdat0), 32'(e));
                end
            end
            pend = rd0 & ~empty0 & ~fl0 & ~rst0;
        end
    end

    // FWFT: the word being popped is compared while the pop is presented.
    initial begin : mon1
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rd1 & ~empty1 & ~fl1 & ~rst1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_data1_unexpected actual=%0h required=none", rdat1);
                end else begin
                    e = q1.pop_front();
                    chk("rd_data1", 32'(rdat1), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        checks = 0; errors = 0;
        rst0 = 1; wr0 = 0; wd0 = 0; rd0 = 0; fl0 = 0; ce0 = 0;
        rst1 = 1; wr1 = 0; wd1 = 0; rd1 = 0; fl1 = 0; ce1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 0; rst1 = 0;

        chk("rst_count0", 32'(cnt0), 0);
        chk("rst_empty0", 32'(empty0), 1);
        chk("rst_full0", 32'(full0), 0);
        chk("rst_ae0", 32'(ae0), 1);
        chk("rst_af0", 32'(af0), 0);
        chk("rst_ovf0", 32'(ovf0), 0);
        chk("rst_udf0", 32'(udf0), 0);
        chk("rst_rdata0", 32'(rdat0), 0);
        chk("rst_empty1", 32'(empty1), 1);
        chk("rst_count1", 32'(cnt1), 0);

        // Fill: almost_full threshold is 2, almost_empty threshold is 1.
        op0(1, 8'h11, 0, 0, 0, 0);
        chk("fill1_count", 32'(cnt0), 1);
        chk("fill1_empty", 32'(empty0), 0);
        chk("fill1_ae", 32'(ae0), 1);
        chk("fill1_af", 32'(af0), 0);
        op0(1, 8'h22, 0, 0, 0, 0);
        chk("fill2_count", 32'(cnt0), 2);
        chk("fill2_af", 32'(af0), 1);
        chk("fill2_ae", 32'(ae0), 0);
        op0(1, 8'h33, 0, 0, 0, 0);
        chk("fill3_count", 32'(cnt0), 3);
        chk("fill3_full", 32'(full0), 0);
        op0(1, 8'h44, 0, 0, 0, 0);
        chk("fill4_count", 32'(cnt0), 4);
        chk("fill4_full", 32'(full0), 1);

        // Overflow is sticky until cleared.
        op0(1, 8'h55, 0, 0, 0, 0);
        chk("ovf_count", 32'(cnt0), 4);
        chk("ovf_set", 32'(ovf0), 1);
        op0(0, 8'h00, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(ovf0), 1);
        op0(0, 8'h00, 0, 0, 1, 0);
        chk("ovf_clear", 32'(ovf0), 0);

        // Write while full passes when a read is accepted the same cycle.
        q0.push_back(8'h11);
        op0(1, 8'h66, 1, 0, 0, 0);
        chk("pass_count", 32'(cnt0), 4);
        chk("pass_full", 32'(full0), 1);
        chk("pass_ovf", 32'(ovf0), 0);
        q0.push_back(8'h22); op0(0, 8'h00, 1, 0, 0, 0);
        chk("drain_count3", 32'(cnt0), 3);
        q0.push_back(8'h33); op0(0, 8'h00, 1, 0, 0, 0);
        q0.push_back(8'h44); op0(0, 8'h00, 1, 0, 0, 0);
        chk("drain_count1", 32'(cnt0), 1);
        q0.push_back(8'h66); op0(0, 8'h00, 1, 0, 0, 0);
        chk("drain_empty", 32'(empty0), 1);
        chk("drain_count0", 32'(cnt0), 0);
        op0(0, 8'h00, 0, 0, 0, 0);

        // Empty with read and write: write accepted, read rejected, no bypass.
        op0(1, 8'hA5, 1, 0, 0, 0);
        chk("udf_set", 32'(udf0), 1);
        chk("udf_count", 32'(cnt0), 1);
        chk("udf_rdata_hold", 32'(rdat0), 32'h66);
        chk("udf_no_ovf", 32'(ovf0), 0);
        op0(0, 8'h00, 0, 0, 1, 0);
        chk("udf_clear", 32'(udf0), 0);
        q0.push_back(8'hA5);
        op0(0, 8'h00, 1, 0, 0, 0);
        chk("a5_empty", 32'(empty0), 1);
        op0(0, 8'h00, 0, 0, 0, 0);

        // Flush with requests: contents dropped, no error flags, read data held.
        op0(1, 8'h01, 0, 0, 0, 0);
        op0(1, 8'h02, 0, 0, 0, 0);
        op0(1, 8'h03, 0, 0, 0, 0);
        chk("preflush_count", 32'(cnt0), 3);
        op0(1, 8'h04, 1, 1, 0, 0);
        chk("flush_count", 32'(cnt0), 0);
        chk("flush_empty", 32'(empty0), 1);
        chk("flush_ovf", 32'(ovf0), 0);
        chk("flush_udf", 32'(udf0), 0);
        chk("flush_rdata", 32'(rdat0), 32'hA5);
        op0(0, 8'h00, 1, 1, 0, 0);
        chk("flush_empty_rd_udf", 32'(udf0), 0);

        // Reset mid-burst with overflow pending and a non-zero read register.
        op0(1, 8'hB0, 0, 0, 0, 0);
        op0(1, 8'hB1, 0, 0, 0, 0);
        op0(1, 8'hB2, 0, 0, 0, 0);
        op0(1, 8'hB3, 0, 0, 0, 0);
        op0(1, 8'hB4, 0, 0, 0, 0);
        chk("burst_ovf", 32'(ovf0), 1);
        q0.push_back(8'hB0);
        op0(0, 8'h00, 1, 0, 0, 0);
        chk("burst_count", 32'(cnt0), 3);
        op0(1, 8'hC0, 1, 0, 0, 1);
        chk("mrst_count", 32'(cnt0), 0);
        chk("mrst_empty", 32'(empty0), 1);
        chk("mrst_full", 32'(full0), 0);
        chk("mrst_ae", 32'(ae0), 1);
        chk("mrst_af", 32'(af0), 0);
        chk("mrst_ovf", 32'(ovf0), 0);
        chk("mrst_udf", 32'(udf0), 0);
        chk("mrst_rdata", 32'(rdat0), 0);

        // FWFT instance: head word visible without a read.
        op1(1, 8'h5A, 0);
        chk("fwft_empty", 32'(empty1), 0);
        chk("fwft_rdata", 32'(rdat1), 32'h5A);
        chk("fwft_count", 32'(cnt1), 1);
        q1.push_back(8'h5A);
        op1(0, 8'h00, 1);
        chk("fwft_pop_empty", 32'(empty1), 1);

        // Streaming through the pointer wrap keeps order.
        op1(1, 8'h10, 0);
        chk("fwft_head10", 32'(rdat1), 32'h10);
        for (int i = 0; i < 10; i++) begin
            q1.push_back(8'(8'h10 + i));
            op1(1, 8'(8'h11 + i), 1);
            chk("fwft_stream_count", 32'(cnt1), 1);
        end
        q1.push_back(8'h1A);
        op1(0, 8'h00, 1);
        chk("fwft_final_empty", 32'(empty1), 1);
        chk("fwft_no_udf", 32'(udf1), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
